// File: rtl/noc_input_port.sv
// NoC router input port: first-word-fall-through flit FIFO with XY route
// computation on the head flit, presented to the switch allocator as a label.
module noc_input_port #(
   parameter int DEPTH    = 8,
   parameter int WIDTH    = 3,
   parameter int DATASIZE = 40,
   parameter int X_ID     = 0,
   parameter int Y_ID     = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                data_valid_in,
   input  logic [DATASIZE-1:0] data_in,
   output logic                full,
   input  logic                ready,
   output logic [3:0]          label,
   output logic [DATASIZE-1:0] data_out,
   output logic [WIDTH:0]      occupancy,
   output logic                overflow
);

   localparam logic [WIDTH:0] FULL_COUNT = (WIDTH+1)'(DEPTH);
   localparam logic [1:0]     MY_X       = 2'(X_ID);
   localparam logic [1:0]     MY_Y       = 2'(Y_ID);

   typedef enum logic [3:0] {
      ROUTE_NONE = 4'd0,
      ROUTE_L    = 4'd1,
      ROUTE_N    = 4'd2,
      ROUTE_E    = 4'd3,
      ROUTE_S    = 4'd4,
      ROUTE_W    = 4'd5
   } route_e;

   logic [DATASIZE-1:0] mem [DEPTH];
   logic [WIDTH-1:0]    wr_ptr;
   logic [WIDTH-1:0]    rd_ptr;
   logic [WIDTH:0]      count;
   logic                push;
   logic                pop;
   logic                empty;
   logic [DATASIZE-1:0] head;
   logic [1:0]          dst_x;
   logic [1:0]          dst_y;
   route_e              route;

   // full is judged before any same-cycle pop, so a push into a full FIFO is lost.
   assign full      = (count == FULL_COUNT);
   assign empty     = (count == '0);
   assign push      = data_valid_in && !full;
   assign pop       = ready && !empty;
   assign occupancy = count;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (data_valid_in && full) overflow <= 1'b1;
      end
   end

   // NOTE: the flit array is deliberately not reset; pointers and count alone
   // define which entries are valid, and a reset memory costs a mux per bit.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_in;
   end

   assign head     = empty ? '0 : mem[rd_ptr];
   assign data_out = head;
   assign dst_x    = head[35:34];
   assign dst_y    = head[33:32];

   always_comb begin
      // NOTE: default first so every path assigns route and no latch is inferred.
      route = ROUTE_NONE;
      if (!empty) begin
         if (dst_x > MY_X)      route = ROUTE_E;
         else if (dst_x < MY_X) route = ROUTE_W;
         else if (dst_y > MY_Y) route = ROUTE_S;
         else if (dst_y < MY_Y) route = ROUTE_N;
         else                   route = ROUTE_L;
      end
   end

   assign label = route;

endmodule

// File: tb/tb_noc_input_port.sv
// Bench for noc_input_port: directed test-plan steps plus random traffic, all
// checked against a queue-based model of the FIFO and the XY routing rules.
module tb_noc_input_port;

   localparam int DEPTH = 8;
   localparam int DS    = 40;

   logic          clk = 1'b0;
   logic          rst;
   logic          data_valid_in;
   logic [DS-1:0] data_in;
   logic          full;
   logic          ready;
   logic [3:0]    label;
   logic [DS-1:0] data_out;
   logic [3:0]    occupancy;
   logic          overflow;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DS-1:0] model_q[$];
   logic          model_ovf = 1'b0;

   noc_input_port #(.DEPTH(DEPTH), .WIDTH(3), .DATASIZE(DS), .X_ID(1), .Y_ID(1)) dut (
      .clk           (clk),
      .rst           (rst),
      .data_valid_in (data_valid_in),
      .data_in       (data_in),
      .full          (full),
      .ready         (ready),
      .label         (label),
      .data_out      (data_out),
      .occupancy     (occupancy),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   // Router sits at (1,1): east/west on x first, then south/north on y.
   function automatic logic [3:0] xy_route(input logic [3:0] dst);
      int dx = int'(dst[3:2]);
      int dy = int'(dst[1:0]);
      if (dx > 1) return 4'd3;
      if (dx < 1) return 4'd5;
      if (dy > 1) return 4'd4;
      if (dy < 1) return 4'd2;
      return 4'd1;
   endfunction

   function automatic logic [DS-1:0] mk_flit(input logic [3:0] dst);
      logic [3:0]  src  = 4'($urandom);
      logic [31:0] rest = $urandom;
      return {src, dst, rest};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [DS-1:0] exp_data = '0;
      logic [3:0]    exp_label = 4'd0;
      if (model_q.size() != 0) begin
         exp_data  = model_q[0];
         exp_label = xy_route(exp_data[35:32]);
      end
      check({tag, ".occupancy"}, 64'(occupancy), 64'(model_q.size()));
      check({tag, ".full"},      64'(full),      64'(model_q.size() == DEPTH));
      check({tag, ".overflow"},  64'(overflow),  64'(model_ovf));
      check({tag, ".data_out"},  64'(data_out),  64'(exp_data));
      check({tag, ".label"},     64'(label),     64'(exp_label));
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then check.
   task automatic step(input string tag, input logic r, input logic v,
                       input logic [DS-1:0] d, input logic rdy);
      bit was_full;
      bit was_empty;
      rst = r; data_valid_in = v; data_in = d; ready = rdy;
      @(posedge clk);
      was_full  = (model_q.size() == DEPTH);
      was_empty = (model_q.size() == 0);
      if (r) begin
         model_q.delete();
         model_ovf = 1'b0;
      end else begin
         if (rdy && !was_empty) void'(model_q.pop_front());
         if (v && !was_full) model_q.push_back(d);
         if (v && was_full) model_ovf = 1'b1;
      end
      #1;
      check_outputs(tag);
   endtask

   initial begin
      logic [DS-1:0] f;
      logic [3:0]    dsts [5] = '{4'b0001, 4'b0100, 4'b0110, 4'b0101, 4'b1001};

      // Reset
      step("reset0", 1'b1, 1'b0, '0, 1'b0);
      step("reset1", 1'b1, 1'b1, mk_flit(4'h5), 1'b1);

      // Single flit east, then pop
      f = mk_flit(4'b1001);
      step("t1_push", 1'b0, 1'b1, f, 1'b0);
      check("t1_label_east", 64'(label), 64'd3);
      check("t1_data", 64'(data_out), 64'(f));
      step("t1_pop", 1'b0, 1'b0, '0, 1'b1);
      check("t1_label_zero", 64'(label), 64'd0);

      // Five routes, then drain
      for (int i = 0; i < 5; i++) step("t2_push", 1'b0, 1'b1, mk_flit(dsts[i]), 1'b0);
      check("t2_occ5", 64'(occupancy), 64'd5);
      check("t2_first_label", 64'(label), 64'd5);
      for (int i = 0; i < 5; i++) step("t2_drain", 1'b0, 1'b0, '0, 1'b1);

      // Fill, then push into full with a same-cycle pop
      for (int i = 0; i < DEPTH; i++) step("t3_fill", 1'b0, 1'b1, mk_flit(4'($urandom)), 1'b0);
      check("t3_full", 64'(full), 64'd1);
      step("t3_overflow", 1'b0, 1'b1, mk_flit(4'($urandom)), 1'b1);
      check("t3_occ7", 64'(occupancy), 64'd7);
      check("t3_ovf_set", 64'(overflow), 64'd1);

      // Down to 3, then push+pop for 20 cycles through pointer wrap
      for (int i = 0; i < 4; i++) step("t4_drain", 1'b0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 20; i++) step("t4_stream", 1'b0, 1'b1, mk_flit(4'($urandom)), 1'b1);
      check("t4_occ3", 64'(occupancy), 64'd3);
      check("t4_ovf_sticky", 64'(overflow), 64'd1);

      // Drain, then ready while empty
      for (int i = 0; i < 3; i++) step("t5_drain", 1'b0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 4; i++) step("t5_empty_ready", 1'b0, 1'b0, '0, 1'b1);

      // Fill to 6, reset with concurrent push and pop
      for (int i = 0; i < 6; i++) step("t6_fill", 1'b0, 1'b1, mk_flit(4'($urandom)), 1'b0);
      step("t6_reset", 1'b1, 1'b1, mk_flit(4'($urandom)), 1'b1);
      check("t6_occ0", 64'(occupancy), 64'd0);
      check("t6_ovf_clear", 64'(overflow), 64'd0);

      // Random traffic with occasional resets
      for (int i = 0; i < 400; i++)
         step("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
              mk_flit(4'($urandom)), 1'($urandom));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
